fire_scheduler: RTL and testbench
=================================

# fire_scheduler

Fire-control scheduler for the ship's shared ammunition magazine. Up to N_REQ weapon mounts request fire. The block grants them round-robin, one at a time, and deducts each mount's per-shot rate from a single saturating magazine count. It also sequences magazine reloads, gates firing on attack mode, and reports dry-fire, wrong-mode and overflow errors. It sits between the weapon mounts and the magazine count, which it owns.

## Interface
Parameters:
- N_REQ, 4: number of requesting weapon mounts.
- AMMO_W, 9: width of ammo count, rates and reload amount.
- MAX_AMMO, 500: magazine capacity.
- RELOAD_CYC, 4: cycles spent in RELOAD.
- COOLDOWN_CYC, 2: cycles spent in COOLDOWN after each shot (only with FIRE_COOLDOWN_EN).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode_selector  in  4  one-hot ship mode; attack = 4'b0010.
- req  in  N_REQ  level fire request per mount.
- rate  in  N_REQ*AMMO_W  per-mount rounds per shot; mount i occupies bits [i*AMMO_W +: AMMO_W].
- reload_req  in  1  single-cycle reload pulse; latched as pending.
- reload_amount  in  AMMO_W  rounds to add, sampled at RELOAD entry.
- grant  out  N_REQ  one-hot, single-cycle shot grant.
- ammo_left  out  AMMO_W  current magazine count.
- reloading  out  1  high while in RELOAD.
- error  out  1  single-cycle error pulse.
- err_code  out  2  cause, valid with error: 01 wrong mode, 10 dry, 11 reload overflow.

## Operation
- Reset values: ammo_left=0, grant=0, error=0, err_code=00, reloading=0, state=IDLE, RR pointer=0, reload pending=0.
- States and transitions:
  - IDLE: if reload pending, go to RELOAD. Else if any req, evaluate the RR candidate (first requester at or after the pointer).
  - FIRE: one cycle. Then COOLDOWN when FIRE_COOLDOWN_EN is defined, else IDLE.
  - COOLDOWN: COOLDOWN_CYC cycles, then IDLE.
  - RELOAD: RELOAD_CYC cycles. On exit, ammo_left = min(ammo_left + reload_amount, MAX_AMMO). Return to IDLE.
- Candidate evaluation in IDLE, in priority order:
  - mode_selector != 4'b0010: error with code 01, no grant, pointer unchanged.
  - rate[cand] > ammo_left or rate[cand]==0: error with code 10, no grant, pointer advances to cand+1 so other mounts are not starved.
  - Otherwise: grant[cand]=1, ammo_left -= rate[cand], pointer = cand+1 (mod N_REQ), go to FIRE.
- Reload overflow: if ammo_left + reload_amount > MAX_AMMO, clamp to MAX_AMMO and pulse error with code 11 on RELOAD exit.
- Arithmetic: the sum is computed at AMMO_W+1 bits before clamping. Subtraction never underflows, because it is guarded by the dry check.
- Reload priority: a pending reload beats any fire request in IDLE.
- A reload_req arriving during FIRE, COOLDOWN or RELOAD is latched. A second pulse while one is pending merges into the same pending flag.
- Requests arriving outside IDLE are ignored until IDLE; no error is raised.
- rst mid-operation aborts any reload (no rounds added), clears pending, and empties the magazine.

## Timing
- Request sampled at edge k in IDLE produces grant and the decremented ammo_left visible after edge k; grant drops after edge k+1.
- Minimum spacing between grants: 2 cycles without the macro, 2+COOLDOWN_CYC with it.
- Reload: pulse at edge k in IDLE sets pending. RELOAD is entered at k+1; reloading is high for RELOAD_CYC cycles; new ammo_left and any code-11 error appear on the exit edge.
- error/err_code are registered and last one cycle. Within RELOAD, grant is never asserted.

## Configuration
- FIRE_COOLDOWN_EN defined: the COOLDOWN state and its cycle counter are present; every FIRE is followed by COOLDOWN_CYC idle-equivalent cycles.
- Undefined: FIRE returns directly to IDLE; COOLDOWN_CYC is unused.

## Structure
- Shared package weapons_pkg:
  - state encoding (IDLE, FIRE, COOLDOWN, RELOAD);
  - err_code constants (ERR_NONE, ERR_MODE, ERR_DRY, ERR_OVF);
  - ATTACK_MODE = 4'b0010.
- One sub-module: rr_arbiter, a combinational round-robin candidate picker. Inputs: req vector and pointer. Outputs: one-hot candidate and its index. Pointer update stays in fire_scheduler.

## Test plan
- Reset, then reload_req with reload_amount=500 in attack mode -> reloading high 4 cycles, ammo_left=500, no error.
- req=4'b0101, rates 5 and 1 -> grants alternate mount0/mount2; ammo_left sequence 495, 494, 489, 488.
- mode_selector=4'b0001 with req=4'b0001 -> error with code 01 each IDLE evaluation; no grant; ammo_left unchanged.
- ammo_left=3, mount0 rate=5, mount1 rate=2, req=4'b0011 -> error code 10 for mount0, then mount1 is granted and ammo_left=1.
- reload_req pulsed during FIRE with ammo_left=400 and reload_amount=200 -> RELOAD starts after the return to IDLE; ammo_left=500; error with code 11 on exit.
- rst asserted in cycle 2 of RELOAD -> all outputs return to reset values on the next edge; pending cleared; ammo_left=0.

Source files
------------

// File: rtl/weapons_pkg.sv
// Shared encodings for the fire-control scheduler: FSM states,
// error codes and the ship mode that enables firing.
package weapons_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRE     = 2'd1,
        COOLDOWN = 2'd2,
        RELOAD   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_MODE = 2'b01;
    localparam logic [1:0] ERR_DRY  = 2'b10;
    localparam logic [1:0] ERR_OVF  = 2'b11;

    localparam logic [3:0] ATTACK_MODE = 4'b0010;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr.
// The pointer itself is owned and advanced by the caller.
module rr_arbiter
    import weapons_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] cand,
    output logic [PTR_W-1:0] cand_idx
);

    always_comb begin
        int   j;
        logic found;
        cand     = '0;
        cand_idx = '0;
        found    = 1'b0;
        j        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                cand[j]  = 1'b1;
                cand_idx = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/fire_scheduler.sv
// Round-robin fire scheduler owning the shared magazine count.
// Define FIRE_COOLDOWN_EN to insert a COOLDOWN phase after every shot.
module fire_scheduler
    import weapons_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int AMMO_W       = 9,
    parameter int MAX_AMMO     = 500,
    parameter int RELOAD_CYC   = 4,
    parameter int COOLDOWN_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              mode_selector,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*AMMO_W-1:0] rate,
    input  logic                    reload_req,
    input  logic [AMMO_W-1:0]       reload_amount,
    output logic [N_REQ-1:0]        grant,
    output logic [AMMO_W-1:0]       ammo_left,
    output logic                    reloading,
    output logic                    error,
    output logic [1:0]              err_code
);

    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CYC_MAX = (RELOAD_CYC > COOLDOWN_CYC) ? RELOAD_CYC : COOLDOWN_CYC;
    localparam int CNT_W   = $clog2(CYC_MAX + 1);

    localparam logic [AMMO_W-1:0] MAX_A   = AMMO_W'(MAX_AMMO);
    localparam logic [AMMO_W:0]   MAX_SUM = (AMMO_W + 1)'(MAX_AMMO);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [PTR_W-1:0]   ptr_q;
    logic               pending_q;
    logic [AMMO_W-1:0]  ammo_q;
    logic [AMMO_W-1:0]  amt_q;
    logic [N_REQ-1:0]   grant_q;
    logic               error_q;
    logic [1:0]         code_q;

    logic [N_REQ-1:0]   cand;
    logic [PTR_W-1:0]   cand_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [AMMO_W-1:0]  cand_rate;
    logic [AMMO_W:0]    reload_sum;
    logic               any_req;
    logic               cnt_done;
    logic               ovf;

    logic start_reload;
    logic reload_done;
    logic mode_bad;
    logic dry;
    logic fire;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req      (req),
        .ptr      (ptr_q),
        .cand     (cand),
        .cand_idx (cand_idx)
    );

    assign any_req    = |req;
    assign cand_rate  = rate[int'(cand_idx)*AMMO_W +: AMMO_W];
    assign next_ptr   = (cand_idx == PTR_W'(N_REQ - 1)) ? '0 : cand_idx + 1'b1;
    assign reload_sum = {1'b0, ammo_q} + {1'b0, amt_q};
    assign ovf        = reload_sum > MAX_SUM;
    assign cnt_done   = (cnt_q == '0);

    // A pending reload always wins over fire requests in IDLE.
    always_comb begin
        start_reload = 1'b0;
        reload_done  = 1'b0;
        mode_bad     = 1'b0;
        dry          = 1'b0;
        fire         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pending_q)
                    start_reload = 1'b1;
                else if (any_req) begin
                    if (mode_selector != ATTACK_MODE)
                        mode_bad = 1'b1;
                    else if (cand_rate == '0 || cand_rate > ammo_q)
                        dry = 1'b1;
                    else
                        fire = 1'b1;
                end
            end
            RELOAD:   reload_done = cnt_done;
            FIRE:     ;
            COOLDOWN: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_reload)
                    state_d = RELOAD;
                else if (fire)
                    state_d = FIRE;
            end
`ifdef FIRE_COOLDOWN_EN
            FIRE:     state_d = COOLDOWN;
`else
            FIRE:     state_d = IDLE;
`endif
            COOLDOWN: if (cnt_done) state_d = IDLE;
            RELOAD:   if (cnt_done) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            pending_q <= 1'b0;
            ammo_q    <= '0;
            amt_q     <= '0;
            grant_q   <= '0;
            error_q   <= 1'b0;
            code_q    <= ERR_NONE;
        end else begin
            state_q <= state_d;
            grant_q <= '0;
            error_q <= 1'b0;
            code_q  <= ERR_NONE;
            if (reload_req)
                pending_q <= 1'b1;
            if (!cnt_done)
                cnt_q <= cnt_q - 1'b1;
            // Pulses on the entry edge merge into the reload being started.
            if (start_reload) begin
                pending_q <= 1'b0;
                amt_q     <= reload_amount;
                cnt_q     <= CNT_W'(RELOAD_CYC - 1);
            end
            if (mode_bad) begin
                error_q <= 1'b1;
                code_q  <= ERR_MODE;
            end
            if (dry) begin
                error_q <= 1'b1;
                code_q  <= ERR_DRY;
                ptr_q   <= next_ptr;
            end
            if (fire) begin
                grant_q <= cand;
                ammo_q  <= ammo_q - cand_rate;
                ptr_q   <= next_ptr;
            end
`ifdef FIRE_COOLDOWN_EN
            if (state_q == FIRE)
                cnt_q <= CNT_W'(COOLDOWN_CYC - 1);
`endif
            if (reload_done) begin
                if (ovf) begin
                    ammo_q  <= MAX_A;
                    error_q <= 1'b1;
                    code_q  <= ERR_OVF;
                end else begin
                    ammo_q <= reload_sum[AMMO_W-1:0];
                end
            end
        end
    end

    assign grant     = grant_q;
    assign ammo_left = ammo_q;
    assign reloading = (state_q == RELOAD);
    assign error     = error_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_fire_scheduler.sv
// Self-checking bench for fire_scheduler: directed vector table,
// hand-written reload/reset sequences and a randomized model run.
module tb_fire_scheduler;

    localparam int N    = 4;
    localparam int W    = 9;
    localparam int MAXA = 500;
    localparam int RC   = 4;
    localparam int CC   = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     mode_selector;
    logic [N-1:0]   req;
    logic [N*W-1:0] rate;
    logic           reload_req;
    logic [W-1:0]   reload_amount;
    logic [N-1:0]   grant;
    logic [W-1:0]   ammo_left;
    logic           reloading;
    logic           error;
    logic [1:0]     err_code;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fire_scheduler #(
        .N_REQ        (N),
        .AMMO_W       (W),
        .MAX_AMMO     (MAXA),
        .RELOAD_CYC   (RC),
        .COOLDOWN_CYC (CC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode_selector (mode_selector),
        .req           (req),
        .rate          (rate),
        .reload_req    (reload_req),
        .reload_amount (reload_amount),
        .grant         (grant),
        .ammo_left     (ammo_left),
        .reloading     (reloading),
        .error         (error),
        .err_code      (err_code)
    );

    // Reference model: magazine as an integer, busy time as a countdown.
    int         m_ammo, m_ptr, m_busy, m_amt;
    bit         m_pend, m_rel, m_err;
    logic [3:0] m_grant;
    logic [1:0] m_code;

    function automatic void model_step();
        int c;
        int r;
        int sum;
        bit np;
        m_grant = '0;
        m_err   = 1'b0;
        m_code  = 2'b00;
        if (rst) begin
            m_ammo = 0; m_ptr = 0; m_busy = 0; m_amt = 0;
            m_pend = 1'b0; m_rel = 1'b0;
            return;
        end
        np = m_pend || reload_req;
        if (m_busy > 0) begin
            m_busy--;
            if (m_rel && m_busy == 0) begin
                m_rel = 1'b0;
                sum = m_ammo + m_amt;
                if (sum > MAXA) begin
                    m_ammo = MAXA; m_err = 1'b1; m_code = 2'b11;
                end else begin
                    m_ammo = sum;
                end
            end
        end else if (m_pend) begin
            m_rel  = 1'b1;
            m_busy = RC;
            m_amt  = int'(reload_amount);
            np     = 1'b0;
        end else if (req != '0) begin
            c = m_ptr;
            while (!req[c]) c = (c + 1) % N;
            r = int'(rate[c*W +: W]);
            if (mode_selector != 4'b0010) begin
                m_err = 1'b1; m_code = 2'b01;
            end else if (r == 0 || r > m_ammo) begin
                m_err = 1'b1; m_code = 2'b10;
                m_ptr = (c + 1) % N;
            end else begin
                m_grant = 4'(1 << c);
                m_ammo  = m_ammo - r;
                m_ptr   = (c + 1) % N;
`ifdef FIRE_COOLDOWN_EN
                m_busy  = 1 + CC;
`else
                m_busy  = 1;
`endif
            end
        end
        m_pend = np;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] g,
                       input logic [W-1:0] am, input logic rel,
                       input logic er, input logic [1:0] cd);
        checks++;
        if ({grant, ammo_left, reloading, error, err_code} !==
            {g, am, rel, er, cd}) begin
            errors++;
            $display("FAIL %s: got grant=%b ammo=%0d rel=%b err=%b code=%b, want grant=%b ammo=%0d rel=%b err=%b code=%b",
                     nm, grant, ammo_left, reloading, error, err_code,
                     g, am, rel, er, cd);
        end
    endtask

    typedef struct packed {
        logic           rs;
        logic [3:0]     md;
        logic [3:0]     rq;
        logic [N*W-1:0] rt;
        logic           rl;
        logic [W-1:0]   amt;
        logic [3:0]     g;
        logic [W-1:0]   am;
        logic           rel;
        logic           er;
        logic [1:0]     cd;
    } vec_t;

    function automatic logic [N*W-1:0] mkrate(int a, int b, int c, int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    function automatic vec_t v(logic rs, logic [3:0] md, logic [3:0] rq,
                               logic [N*W-1:0] rt, logic rl, int amt,
                               logic [3:0] g, int am, logic rel,
                               logic er, logic [1:0] cd);
        vec_t x;
        x = {rs, md, rq, rt, rl, W'(amt), g, W'(am), rel, er, cd};
        return x;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [N*W-1:0] ra, rb;
        ra = mkrate(5, 0, 1, 0);
        rb = mkrate(5, 2, 0, 1);

        rst = 1'b1; mode_selector = 4'b0010; req = '0; rate = '0;
        reload_req = 1'b0; reload_amount = '0;

        // reset, then a full 500-round reload
        tbl.push_back(v(1, 4'b0010, 4'b0000, ra, 0, 500, 4'b0000,   0, 0, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0000, ra, 1, 500, 4'b0000,   0, 0, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0000, ra, 0, 500, 4'b0000,   0, 1, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0000, ra, 0, 500, 4'b0000,   0, 1, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0000, ra, 0, 500, 4'b0000,   0, 1, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0000, ra, 0, 500, 4'b0000,   0, 1, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0000, ra, 0, 500, 4'b0000, 500, 0, 0, 2'b00));
        // alternating grants for mounts 0 and 2
        tbl.push_back(v(0, 4'b0010, 4'b0101, ra, 0, 0, 4'b0001, 495, 0, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0101, ra, 0, 0, 4'b0000, 495, 0, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0101, ra, 0, 0, 4'b0100, 494, 0, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0101, ra, 0, 0, 4'b0000, 494, 0, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0101, ra, 0, 0, 4'b0001, 489, 0, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0101, ra, 0, 0, 4'b0000, 489, 0, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0101, ra, 0, 0, 4'b0100, 488, 0, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0101, ra, 0, 0, 4'b0000, 488, 0, 0, 2'b00));
        // wrong mode
        tbl.push_back(v(0, 4'b0001, 4'b0001, ra, 0, 0, 4'b0000, 488, 0, 1, 2'b01));
        tbl.push_back(v(0, 4'b0001, 4'b0001, ra, 0, 0, 4'b0000, 488, 0, 1, 2'b01));
        // reset, reload 3 rounds
        tbl.push_back(v(1, 4'b0001, 4'b0000, rb, 0, 3, 4'b0000, 0, 0, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0000, rb, 1, 3, 4'b0000, 0, 0, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0000, rb, 0, 3, 4'b0000, 0, 1, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0000, rb, 0, 3, 4'b0000, 0, 1, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0000, rb, 0, 3, 4'b0000, 0, 1, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0000, rb, 0, 3, 4'b0000, 0, 1, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0000, rb, 0, 3, 4'b0000, 3, 0, 0, 2'b00));
        // dry mount 0 skipped, mount 1 granted; zero rate; exact fit
        tbl.push_back(v(0, 4'b0010, 4'b0011, rb, 0, 0, 4'b0000, 3, 0, 1, 2'b10));
        tbl.push_back(v(0, 4'b0010, 4'b0011, rb, 0, 0, 4'b0010, 1, 0, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0000, rb, 0, 0, 4'b0000, 1, 0, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0100, rb, 0, 0, 4'b0000, 1, 0, 1, 2'b10));
        tbl.push_back(v(0, 4'b0010, 4'b1000, rb, 0, 0, 4'b1000, 0, 0, 0, 2'b00));
        tbl.push_back(v(0, 4'b0010, 4'b0000, rb, 0, 0, 4'b0000, 0, 0, 0, 2'b00));

        foreach (tbl[i]) begin
            rst           = tbl[i].rs;
            mode_selector = tbl[i].md;
            req           = tbl[i].rq;
            rate          = tbl[i].rt;
            reload_req    = tbl[i].rl;
            reload_amount = tbl[i].amt;
            tick();
            chk($sformatf("vec%0d", i), tbl[i].g, tbl[i].am,
                tbl[i].rel, tbl[i].er, tbl[i].cd);
        end

        // reload pulsed during FIRE, overflow clamp, reload beats request
        rst = 1'b1; req = '0; reload_req = 1'b0; tick();
        rst = 1'b0; mode_selector = 4'b0010;
        reload_req = 1'b1; reload_amount = 9'd410; tick();
        reload_req = 1'b0;
        for (int i = 0; i < RC; i++) tick();
        tick();
        chk("fill410", 4'b0000, 9'd410, 0, 0, 2'b00);
        rate = mkrate(10, 0, 0, 0); req = 4'b0001; tick();
        chk("shot400", 4'b0001, 9'd400, 0, 0, 2'b00);
        reload_req = 1'b1; reload_amount = 9'd200; tick();
        chk("pend_in_fire", 4'b0000, 9'd400, 0, 0, 2'b00);
        reload_req = 1'b0; tick();
        chk("reload_wins", 4'b0000, 9'd400, 1, 0, 2'b00);
        for (int i = 1; i < RC; i++) begin
            tick();
            chk("reload_hold", 4'b0000, 9'd400, 1, 0, 2'b00);
        end
        tick();
        chk("ovf_exit", 4'b0000, 9'd500, 0, 1, 2'b11);
        tick();
        chk("fire_after", 4'b0001, 9'd490, 0, 0, 2'b00);
        req = '0; tick();

        // reset in the second RELOAD cycle with a further reload pending
        reload_req = 1'b1; reload_amount = 9'd100; tick();
        reload_req = 1'b0; tick();
        chk("rl_c1", 4'b0000, 9'd490, 1, 0, 2'b00);
        reload_req = 1'b1; tick();
        chk("rl_c2", 4'b0000, 9'd490, 1, 0, 2'b00);
        reload_req = 1'b0; rst = 1'b1; tick();
        chk("rst_mid", 4'b0000, 9'd0, 0, 0, 2'b00);
        rst = 1'b0;
        for (int i = 0; i < RC + 2; i++) begin
            tick();
            chk("no_pend", 4'b0000, 9'd0, 0, 0, 2'b00);
        end

        // randomized run against the model
        rst = 1'b1; tick();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 299) == 0);
            mode_selector = ($urandom_range(0, 9) == 0) ? 4'(1 << $urandom_range(0, 3))
                                                        : 4'b0010;
            req           = 4'($urandom_range(0, 15));
            for (int m = 0; m < N; m++)
                rate[m*W +: W] = ($urandom_range(0, 9) == 0) ? '0
                                 : W'($urandom_range(1, 60));
            reload_req    = ($urandom_range(0, 11) == 0);
            reload_amount = W'($urandom_range(0, 511));
            tick();
            chk("rand", m_grant, W'(m_ammo), m_rel, m_err, m_code);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
